// File: rtl/ysyx_23060184_axil_sram.sv
// AXI4-Lite word-organised SRAM responder with independent read/write FSMs
// and programmable fixed response latency per channel.
module ysyx_23060184_axil_sram #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    DEPTH_WORDS = 1024,
  parameter int                    RD_LATENCY  = 2,
  parameter int                    WR_LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int                  IDX_W   = $clog2(DEPTH_WORDS);
  localparam int                  LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int                  CNT_W   = $clog2(LAT_MAX) + 1;
  localparam logic [CNT_W-1:0]    RD_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0]    WR_LOAD = CNT_W'(WR_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] SPAN    = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);
  localparam logic [1:0]          OKAY    = 2'b00;
  localparam logic [1:0]          DECERR  = 2'b11;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_t;

  r_state_t              r_state_reg, r_state_next;
  logic [CNT_W-1:0]      r_cnt_reg, r_cnt_next;
  logic [ADDR_WIDTH-1:0] r_addr_reg, r_addr_next;
  logic [1:0]            rresp_reg, rresp_next;
  logic                  r_hit_reg, r_hit_next;
  logic                  rd_load;

  w_state_t              w_state_reg, w_state_next;
  logic [CNT_W-1:0]      w_cnt_reg, w_cnt_next;
  logic [ADDR_WIDTH-1:0] w_addr_reg, w_addr_next;
  logic [DATA_WIDTH-1:0] w_data_reg, w_data_next;
  logic [3:0]            w_strb_reg, w_strb_next;
  logic                  aw_got_reg, aw_got_next;
  logic                  w_got_reg, w_got_next;
  logic [1:0]            bresp_reg, bresp_next;
  logic                  mem_we;

  // Holds the ready outputs low during reset and releases them on the first edge after it.
  logic                  up_reg;

  logic [ADDR_WIDTH-1:0] r_off, w_off;
  logic                  r_in_range, w_in_range;
  logic [IDX_W-1:0]      r_idx, w_idx;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  ar_hs, aw_hs, w_hs;

  assign r_off      = r_addr_reg - BASE_ADDR;
  assign w_off      = w_addr_reg - BASE_ADDR;
  assign r_in_range = (r_addr_reg >= BASE_ADDR) && ({1'b0, r_off} < SPAN);
  assign w_in_range = (w_addr_reg >= BASE_ADDR) && ({1'b0, w_off} < SPAN);
  assign r_idx      = r_off[IDX_W+1:2];
  assign w_idx      = w_off[IDX_W+1:2];

  assign arready = up_reg && (r_state_reg == R_IDLE);
  assign awready = up_reg && (w_state_reg == W_IDLE) && !aw_got_reg;
  assign wready  = up_reg && (w_state_reg == W_IDLE) && !w_got_reg;
  assign ar_hs   = arvalid && arready;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  assign rvalid  = (r_state_reg == R_RESP);
  assign bvalid  = (w_state_reg == W_RESP);
  assign rresp   = rresp_reg;
  assign bresp   = bresp_reg;
  // Out-of-range reads mask the (arbitrary) array word to zero.
  assign rdata   = r_hit_reg ? mem_q : '0;

  always_comb begin
    r_state_next = r_state_reg;
    r_cnt_next   = r_cnt_reg;
    r_addr_next  = r_addr_reg;
    rresp_next   = rresp_reg;
    r_hit_next   = r_hit_reg;
    rd_load      = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        if (ar_hs) begin
          r_addr_next  = araddr;
          r_cnt_next   = RD_LOAD;
          r_state_next = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_reg == '0) begin
          rd_load      = 1'b1;
          r_hit_next   = r_in_range;
          rresp_next   = r_in_range ? OKAY : DECERR;
          r_state_next = R_RESP;
        end else begin
          r_cnt_next = r_cnt_reg - 1'b1;
        end
      end
      R_RESP: begin
        if (rready) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_next = w_state_reg;
    w_cnt_next   = w_cnt_reg;
    w_addr_next  = w_addr_reg;
    w_data_next  = w_data_reg;
    w_strb_next  = w_strb_reg;
    aw_got_next  = aw_got_reg;
    w_got_next   = w_got_reg;
    bresp_next   = bresp_reg;
    mem_we       = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_next = 1'b1;
          w_addr_next = awaddr;
        end
        if (w_hs) begin
          w_got_next  = 1'b1;
          w_data_next = wdata;
          w_strb_next = wstrb;
        end
        if ((aw_got_reg || aw_hs) && (w_got_reg || w_hs)) begin
          w_cnt_next   = WR_LOAD;
          w_state_next = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_cnt_reg == '0) begin
          mem_we       = w_in_range;
          bresp_next   = w_in_range ? OKAY : DECERR;
          w_state_next = W_RESP;
        end else begin
          w_cnt_next = w_cnt_reg - 1'b1;
        end
      end
      W_RESP: begin
        if (bready) begin
          aw_got_next  = 1'b0;
          w_got_next   = 1'b0;
          w_state_next = W_IDLE;
        end
      end
      default: begin
        aw_got_next  = 1'b0;
        w_got_next   = 1'b0;
        w_state_next = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      up_reg      <= 1'b0;
      r_state_reg <= R_IDLE;
      r_cnt_reg   <= '0;
      r_addr_reg  <= '0;
      rresp_reg   <= OKAY;
      r_hit_reg   <= 1'b0;
      w_state_reg <= W_IDLE;
      w_cnt_reg   <= '0;
      w_addr_reg  <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      aw_got_reg  <= 1'b0;
      w_got_reg   <= 1'b0;
      bresp_reg   <= OKAY;
    end else begin
      up_reg      <= 1'b1;
      r_state_reg <= r_state_next;
      r_cnt_reg   <= r_cnt_next;
      r_addr_reg  <= r_addr_next;
      rresp_reg   <= rresp_next;
      r_hit_reg   <= r_hit_next;
      w_state_reg <= w_state_next;
      w_cnt_reg   <= w_cnt_next;
      w_addr_reg  <= w_addr_next;
      w_data_reg  <= w_data_next;
      w_strb_reg  <= w_strb_next;
      aw_got_reg  <= aw_got_next;
      w_got_reg   <= w_got_next;
      bresp_reg   <= bresp_next;
    end
  end

  // One byte-wide array per lane so each strobe maps onto its own RAM write enable.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] q_reg;
      always_ff @(posedge clk) begin
        if (mem_we && w_strb_reg[gi]) mem[w_idx] <= w_data_reg[gi*8 +: 8];
        if (rd_load) q_reg <= mem[r_idx];
      end
      assign mem_q[gi*8 +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: tb/tb_ysyx_23060184_axil_sram.sv
// Directed bench for ysyx_23060184_axil_sram: latency, strobes, split AW/W,
// back-pressure, decode errors and reset during a pending write.
module tb_ysyx_23060184_axil_sram;

  logic        clk;
  logic        rstn;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int checks = 0;
  int passed = 0;

  ysyx_23060184_axil_sram dut (
    .clk(clk), .rstn(rstn),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues AW and W together; lat counts edges after capture until bvalid.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    $display("write addr=%h data=%h strb=%h bresp=%0d lat=%0d", a, d, s, resp, lat);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    $display("read  addr=%h data=%h rresp=%0d lat=%0d", a, d, resp, lat);
  endtask

  logic [31:0] d;
  logic [1:0]  resp;
  int          lat;

  initial begin
    rstn = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    chk("rst_rresp",   {30'd0, rresp},   32'd0);
    chk("rst_bresp",   {30'd0, bresp},   32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_arready", {31'd0, arready}, 32'd1);
    chk("post_awready", {31'd0, awready}, 32'd1);
    chk("post_wready",  {31'd0, wready},  32'd1);

    // Single write then read
    axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, resp, lat);
    chk("w1_lat",   lat,            32'd2);
    chk("w1_bresp", {30'd0, resp},  32'd0);
    axi_read(32'h8000_0010, d, resp, lat);
    chk("r1_lat",   lat,            32'd2);
    chk("r1_data",  d,              32'hDEAD_BEEF);
    chk("r1_rresp", {30'd0, resp},  32'd0);

    // Byte strobes
    axi_write(32'h8000_0020, 32'h1122_3344, 4'hF, resp, lat);
    axi_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, resp, lat);
    axi_read(32'h8000_0020, d, resp, lat);
    chk("strb_data", d, 32'h11BB_33DD);

    // Split AW (cycle 0) and W (cycle 3)
    @(negedge clk);
    awaddr = 32'h8000_0030; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("split_awready_c0", {31'd0, awready}, 32'd0);
    chk("split_wready_c0",  {31'd0, wready},  32'd1);
    @(negedge clk);
    chk("split_wready_c1",  {31'd0, wready},  32'd1);
    @(negedge clk);
    chk("split_wready_c2",  {31'd0, wready},  32'd1);
    chk("split_bvalid_c2",  {31'd0, bvalid},  32'd0);
    wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("split_wready_c3",  {31'd0, wready},  32'd0);
    lat = 0;
    while (!bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("split_lat",   lat,           32'd2);
    chk("split_bresp", {30'd0, bresp}, 32'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    $display("write split addr=80000030 data=5555aaaa lat=%0d", lat);
    axi_read(32'h8000_0030, d, resp, lat);
    chk("split_data", d, 32'h5555_AAAA);

    // Back-pressure: rready held low for 5 cycles after rvalid
    @(negedge clk);
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", lat, 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid",  {31'd0, rvalid},  32'd1);
      chk("bp_rdata",   rdata,            32'hDEAD_BEEF);
      chk("bp_arready", {31'd0, arready}, 32'd0);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("bp_rvalid_after",  {31'd0, rvalid},  32'd0);
    chk("bp_arready_after", {31'd0, arready}, 32'd1);
    $display("read  backpressure addr=80000010 done");

    // Decode errors and range boundaries
    axi_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, resp, lat);
    axi_write(32'h8000_0FFC, 32'h0BAD_C0DE, 4'hF, resp, lat);
    chk("last_bresp", {30'd0, resp}, 32'd0);
    axi_read(32'h8000_0FFC, d, resp, lat);
    chk("last_data",  d,             32'h0BAD_C0DE);
    chk("last_rresp", {30'd0, resp}, 32'd0);
    axi_read(32'h7FFF_FFFC, d, resp, lat);
    chk("oor_rresp", {30'd0, resp}, 32'd3);
    chk("oor_rdata", d,             32'd0);
    axi_write(32'h8000_1000, 32'h1234_5678, 4'hF, resp, lat);
    chk("oor_bresp", {30'd0, resp}, 32'd3);
    axi_read(32'h8000_0000, d, resp, lat);
    chk("oor_word0", d, 32'hCAFE_F00D);
    axi_read(32'h8000_0FFC, d, resp, lat);
    chk("oor_last",  d, 32'h0BAD_C0DE);
    axi_read(32'h8000_0010, d, resp, lat);
    chk("oor_w10",   d, 32'hDEAD_BEEF);

    // Reset while the write is still waiting to commit
    @(negedge clk);
    awaddr = 32'h8000_0020; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid_rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("mid_rst_awready", {31'd0, awready}, 32'd0);
    $display("write aborted by reset addr=80000020");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, arready}, 32'd1);
    axi_read(32'h8000_0020, d, resp, lat);
    chk("mid_rst_data", d, 32'h11BB_33DD);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL timeout: simulation did not complete");
  end

endmodule

// File: doc/ysyx_23060184_axil_sram.md
# ysyx_23060184_axil_sram

AXI4-Lite memory responder that sits on the slave side of the shared memory bus, behind the IFU/LSU arbiter. It answers read and write transactions from whichever master currently holds the grant, using a word-organised internal array. Each channel has a programmable fixed response latency, so the master-side handshakes and the arbiter release path are exercised under realistic wait states. Reads and writes are served by two independent state machines.

## Interface
- DATA_WIDTH, 32, data bus width; must be 32.
- ADDR_WIDTH, 32, address bus width.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- RD_LATENCY, 2, cycles from AR handshake to rvalid; must be ≥1.
- WR_LATENCY, 2, cycles from AW+W capture to bvalid; must be ≥1.
- clk  in  1  single clock; all state changes on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- araddr  in  ADDR_WIDTH  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response: 2'b00 OKAY, 2'b11 DECERR.
- rvalid  out  1  read data valid.
- rready  in  1  master accepts read data.
- awaddr  in  ADDR_WIDTH  write address.
- awvalid / awready  in / out  1  write address handshake.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  4  byte enables; bit i enables byte lane i.
- wvalid / wready  in / out  1  write data handshake.
- bresp  out  2  write response; same encoding as rresp.
- bvalid / bready  out / in  1  write response handshake.

## Operation
- Address decode: the access is in range when BASE_ADDR ≤ addr < BASE_ADDR + 4·DEPTH_WORDS.
  - Word index = (addr − BASE_ADDR) >> 2. addr[1:0] is ignored, so accesses are always word-aligned.
  - An out-of-range access gets DECERR. Out-of-range reads return rdata = 0. Out-of-range writes leave the array unchanged.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready = 1. On arvalid && arready: latch araddr, load cnt = RD_LATENCY−1, go to R_WAIT.
  - R_WAIT: if cnt == 0, load rdata/rresp from the array and go to R_RESP. Otherwise decrement cnt.
  - R_RESP: rvalid = 1. rdata and rresp are held stable. On rready, go to R_IDLE.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE: awready = !aw_got and wready = !w_got. AW and W are captured independently, in either order or in the same cycle.
  - The edge on which the second of the two is captured loads cnt = WR_LATENCY−1 and moves to W_WAIT.
  - W_WAIT: if cnt == 0, commit the enabled byte lanes to the array, set bresp, and go to W_RESP. Otherwise decrement cnt.
  - W_RESP: bvalid = 1. On bready, clear aw_got and w_got and go to W_IDLE.
- Read and write FSMs are fully independent; both may be busy at once.
- Same word read and written with the commit and the read-data load on the same edge: the read returns the old data.
- The array is not reset; its contents are undefined until written.
- Illegal FSM encodings recover to the IDLE state on the next edge.

## Timing
- Reset, while rstn = 0 (asynchronous):
  - arready = awready = wready = 0.
  - rvalid = bvalid = 0; rdata = 0; rresp = bresp = 2'b00.
  - Both FSMs go to IDLE; aw_got = w_got = 0; counters = 0.
- First edge after rstn deasserts: arready = awready = wready = 1.
- Read latency: AR handshake on edge N gives rvalid = 1 after edge N+RD_LATENCY.
  - rvalid stays high until the edge where rready = 1; it is low after that edge.
  - Next arready is high the cycle after the R handshake. Maximum throughput is one read per RD_LATENCY+2 cycles.
- Write latency: with the last of AW/W captured on edge N, the array is updated and bvalid = 1 after edge N+WR_LATENCY.
- While waiting or responding, arready, awready and wready are 0 (the latter two once their beat is captured). No second transaction is accepted per channel.
- Reset asserted mid-transaction aborts it immediately. A write that has not reached its commit edge does not modify the array.

## Test plan
- Reset then single write then read:
  - Write 32'hDEAD_BEEF to 0x8000_0010 with wstrb = 4'hF, then read 0x8000_0010 with RD_LATENCY = 2.
  - Required: bvalid 2 cycles after capture, bresp = 00; rvalid exactly 2 cycles after the AR handshake, rdata = 32'hDEAD_BEEF, rresp = 00.
- Byte strobes:
  - Word holds 32'h1122_3344; write 32'hAABB_CCDD with wstrb = 4'b0101.
  - Required: readback = 32'h11BB_33DD.
- Split AW/W:
  - awvalid on cycle 0, wvalid on cycle 3.
  - Required: awready drops after cycle 0, wready stays high until cycle 3, bvalid after cycle 3+WR_LATENCY.
- Back-pressure:
  - Hold rready = 0 for 5 cycles after rvalid.
  - Required: rvalid and rdata stable throughout, arready = 0; one cycle after rready, arready = 1.
- Decode error:
  - Read 0x7FFF_FFFC; write 0x8000_1000 with DEPTH_WORDS = 1024.
  - Required: rresp = 11 with rdata = 0; bresp = 11; array unchanged, checked by reading all touched words.
- Reset mid-write:
  - Drop rstn while in W_WAIT.
  - Required: bvalid = 0 immediately; the target word keeps its old value after reset.
